dmem_lane_arb: RTL

- Arbiter that shares one single-port data RAM between the two issue lanes (a = older, b = younger) of the dual-issue rv32i core.
- Sits between the core's MEM-stage lane signals and the RAM.
- A same-cycle access by both lanes is serialised over two cycles, a first, then b; the core is stalled for the first cycle.
- Counts conflict cycles for the performance statistics.

---
 rtl/dmem_lane_arb_pkg.sv | 18 +
 rtl/dmem_lane_arb_sat_cnt.sv | 40 ++++
 rtl/dmem_lane_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_lane_arb_pkg.sv
// Shared definitions for the data-RAM lane arbiter.
// Contents: default data/address widths, arbiter state encoding and the
// active-low reset level constants used by the arbiter and its counter.
package dmem_lane_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_SERVE_B = 1'b1
  } arb_state_e;

  // Level of an active-low reset/clear input when it is asserted / released.
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

endpackage

// File: rtl/dmem_lane_arb_sat_cnt.sv
// Width-parameterised saturating up-counter with a synchronous active-low
// clear. Used for the conflict-cycle statistic and reusable for the other
// stall counters.
// Ports:
//   clk   - clock
//   clr_n - synchronous active-low clear (counter goes to zero)
//   inc   - count one event this cycle
//   cnt   - current count, sticks at all-ones
module dmem_lane_arb_sat_cnt
  import dmem_lane_arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_n == DISABLE_N && inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_n == ENABLE_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_lane_arb.sv
// Shares one single-port data RAM between the two issue lanes of the
// dual-issue core (lane a = older, lane b = younger). A same-cycle access by
// both lanes is split over two cycles: lane a first while the core is
// stalled, then lane b. Lane a's load data from the first cycle is held so
// both results are presented together in the second cycle.
//
// Handshake: req_x marks a valid access for the current cycle. stall=1
// means the core must hold all lane inputs stable into the next cycle; an
// access is complete in any cycle where stall=0.
//
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   req_a/we_a/addr_a/wd_a          - lane a access (older instruction)
//   req_b/we_b/addr_b/wd_b          - lane b access (younger instruction)
//   flush                           - abandon a pending lane b access
//   rd_a, rd_b                      - load data returned to each lane
//   stall                           - freeze the core this cycle
//   ram_addr/ram_wd/ram_we, ram_rd  - RAM port (combinational read)
//   conf_cnt                        - saturating count of conflict cycles
//   dbg_state                       - current arbiter state
module dmem_lane_arb
  import dmem_lane_arb_pkg::*;
#(
  parameter int DATA_W = dmem_lane_arb_pkg::DATA_W,
  parameter int ADDR_W = dmem_lane_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rd,
  output logic [DATA_W-1:0] conf_cnt,
  output logic              dbg_state
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_a_q, hold_a_d;
  logic              in_reset;
  logic              conflict;

  assign in_reset = (rst_n == ENABLE_N);

  // A conflict only exists in IDLE; flush cancels the second cycle, and the
  // lane a access of this cycle goes ahead regardless.
  assign conflict = !in_reset && (state_q == ARB_IDLE) && req_a && req_b && !flush;

  always_comb begin
    ram_addr = addr_a;
    ram_wd   = wd_a;
    ram_we   = 1'b0;
    rd_a     = ram_rd;
    rd_b     = ram_rd;
    stall    = 1'b0;
    state_d  = ARB_IDLE;
    hold_a_d = hold_a_q;

    if (state_q == ARB_SERVE_B) begin
      // Lane a completed last cycle; only lane b touches the RAM now.
      ram_addr = addr_b;
      ram_wd   = wd_b;
      ram_we   = we_b && req_b && !flush;
      rd_a     = hold_a_q;
    end else begin
      if (req_b && !req_a) begin
        ram_addr = addr_b;
        ram_wd   = wd_b;
        ram_we   = we_b;
      end else begin
        ram_we   = req_a && we_a;
      end
      if (conflict) begin
        stall    = 1'b1;
        hold_a_d = ram_rd;
        state_d  = ARB_SERVE_B;
      end
    end

    // Reset drops any pending access and blocks writes immediately.
    if (in_reset) begin
      ram_we   = 1'b0;
      stall    = 1'b0;
      state_d  = ARB_IDLE;
      hold_a_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q  <= ARB_IDLE;
      hold_a_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
    end
  end

  dmem_lane_arb_sat_cnt #(
    .W(DATA_W)
  ) u_conf_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .inc  (conflict),
    .cnt  (conf_cnt)
  );

  assign dbg_state = state_q;

endmodule
